control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter NUM_STEPS, default 5, microsteps per instruction; legal value is exactly 5.
REQ-002 Parameter OPC_W, default 4, opcode width from the instruction register upper nibble.
REQ-003 i_clk  input  1  clock; all state advances on the rising edge.
REQ-004 i_rstn  input  1  reset: asynchronous, active-low.
REQ-005 i_opcode  input  OPC_W  current instruction opcode from the IR.
REQ-006 i_zero  input  1  ALU zero flag, registered in the flags block.
REQ-007 i_carry  input  1  ALU carry flag, registered in the flags block.
REQ-008 i_pc_overflow  input  1  program counter wrap indication.
REQ-009 o_pc_cntn / o_pc_den / o_pc_din  output  1 each  PC increment / drive bus / load from bus; active-low.
REQ-010 o_mar_inn, o_ram_den, o_ir_inn, o_ir_den, o_a_inn, o_a_den, o_b_inn, o_alu_den, o_flags_inn  output  1 each  active-low unit strobes (load = *_inn, drive bus = *_den).
REQ-011 o_step  output  3  current microstep, 0..4.
REQ-012 o_halt  output  1  high while halted.

Function
REQ-013 The sequencer SHALL hold a 3-bit step register and a 1-bit halt register, both updated only on the rising edge of i_clk.
REQ-014 The step SHALL advance 0->1->2->3->4->0 each cycle when not halted; no early termination.
REQ-015 Strobe outputs SHALL be a combinational decode of step, i_opcode, i_zero and i_carry.
REQ-016 Every strobe not listed for a step SHALL be 1 (inactive).
REQ-017 At most one *_den strobe SHALL be 0 in any cycle.
REQ-018 Fetch, all opcodes, step 0: o_pc_den=0, o_mar_inn=0.
REQ-019 Fetch, all opcodes, step 1: o_ram_den=0, o_ir_inn=0, o_pc_cntn=0.
REQ-020 0x0 NOP: steps 2-4 idle.
REQ-021 0x1 LDA: step 2 o_ir_den=0, o_mar_inn=0; step 3 o_ram_den=0, o_a_inn=0; step 4 idle.
REQ-022 0x2 ADD: step 2 o_ir_den=0, o_mar_inn=0; step 3 o_ram_den=0, o_b_inn=0; step 4 o_alu_den=0, o_a_inn=0, o_flags_inn=0.
REQ-023 0x3 JMP: step 2 o_ir_den=0, o_pc_din=0; steps 3-4 idle.
REQ-024 0x4 JZ: as JMP when i_zero=1 during step 2; otherwise steps 2-4 idle.
REQ-025 0x5 JC: as JMP when i_carry=1 during step 2; otherwise steps 2-4 idle.
REQ-026 0xF HLT: at the end of step 2 the halt register SHALL set.
REQ-027 Opcodes 0x6-0xE SHALL execute as NOP.
REQ-028 If i_pc_overflow=1 at a rising edge while step=1, the halt register SHALL set on that edge.
REQ-029 Overflow halt is the program running off address 0xFF; the incremented fetch still completes in that cycle.
REQ-030 While halted: all strobes 1, o_halt=1, step frozen at its value when halt set; exit only via reset.
REQ-031 If HLT decode and overflow coincide, the single halt SHALL result, with no other side effect.

Reset
REQ-032 While i_rstn=0: step=0, halt=0, o_halt=0, o_step=0.
REQ-033 While i_rstn=0, all active-low strobes SHALL be forced to 1, gated by i_rstn, irrespective of decode.
REQ-034 Reset assertion mid-instruction SHALL abort the instruction immediately, asynchronously.
REQ-035 After i_rstn rises, the first rising edge of i_clk SHALL execute step 0 decode, with fetch strobes visible combinationally from deassertion.

Verification
REQ-036 Reset then 5 clocks with i_opcode=0x0 -> o_step sequence 0,1,2,3,4; only fetch strobes low in steps 0-1; idle in steps 2-4.
REQ-037 i_opcode=0x2 -> step 4 shows o_alu_den=0, o_a_inn=0, o_flags_inn=0, all other strobes 1.
REQ-038 i_opcode=0x4 with i_zero=0 -> o_pc_din=1 at step 2; repeat with i_zero=1 -> o_pc_din=0, o_ir_den=0 at step 2.
REQ-039 i_opcode=0xF -> o_halt=1 after step 2 edge; 10 further clocks -> o_step stays 2, all strobes 1.
REQ-040 i_pc_overflow=1 during step 1 -> o_halt=1 next cycle.
REQ-041 Halt-exit check: pulse i_rstn low -> o_halt=0, o_step=0; fetch resumes.
REQ-042 Assert i_rstn low at step 3 of LDA -> all strobes 1 within the same cycle with no clock edge, o_step=0.
REQ-043 Every scenario: assertion that no two *_den strobes are 0 simultaneously.

Source files
------------

// File: rtl/control_sequencer.sv
// Five-step microcode sequencer for the 8-bit CPU: fetch in steps 0-1, execute in 2-4.
// Strobes are a combinational, active-low decode of the step, opcode and flags.
module control_sequencer #(
  parameter int unsigned NUM_STEPS = 5,
  parameter int unsigned OPC_W     = 4
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [OPC_W-1:0] i_opcode,
  input  logic             i_zero,
  input  logic             i_carry,
  input  logic             i_pc_overflow,
  output logic             o_pc_cntn,
  output logic             o_pc_den,
  output logic             o_pc_din,
  output logic             o_mar_inn,
  output logic             o_ram_den,
  output logic             o_ir_inn,
  output logic             o_ir_den,
  output logic             o_a_inn,
  output logic             o_a_den,
  output logic             o_b_inn,
  output logic             o_alu_den,
  output logic             o_flags_inn,
  output logic [2:0]       o_step,
  output logic             o_halt
);

  localparam logic [2:0] S_T0   = 3'd0;
  localparam logic [2:0] S_T1   = 3'd1;
  localparam logic [2:0] S_T2   = 3'd2;
  localparam logic [2:0] S_T3   = 3'd3;
  localparam logic [2:0] S_T4   = 3'd4;
  localparam logic [2:0] S_LAST = 3'(NUM_STEPS - 1);

  localparam logic [OPC_W-1:0] OP_LDA = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_JZ  = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_JC  = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(15);

  logic [2:0] step_q, step_d;
  logic       halt_q, halt_d;
  logic       strobe_en_c;
  logic       jump_c;
  logic en_pc_cnt, en_pc_den, en_pc_din, en_mar_in, en_ram_den, en_ir_in;
  logic en_ir_den, en_a_in, en_b_in, en_alu_den, en_flags_in;

  // State register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      step_q <= S_T0;
      halt_q <= 1'b0;
    end else begin
      step_q <= step_d;
      halt_q <= halt_d;
    end
  end

  // Next state: halting freezes the step at the step in which halt was taken
  always_comb begin
    step_d = step_q;
    halt_d = halt_q;
    if (!halt_q) begin
      if ((step_q == S_T1 && i_pc_overflow) || (step_q == S_T2 && i_opcode == OP_HLT)) begin
        halt_d = 1'b1;
      end else if (step_q == S_LAST) begin
        step_d = S_T0;
      end else begin
        step_d = step_q + 3'd1;
      end
    end
  end

  assign jump_c = (i_opcode == OP_JMP) || (i_opcode == OP_JZ && i_zero) ||
                  (i_opcode == OP_JC && i_carry);

  // Active-high microcode decode
  always_comb begin
    en_pc_cnt   = 1'b0;
    en_pc_den   = 1'b0;
    en_pc_din   = 1'b0;
    en_mar_in   = 1'b0;
    en_ram_den  = 1'b0;
    en_ir_in    = 1'b0;
    en_ir_den   = 1'b0;
    en_a_in     = 1'b0;
    en_b_in     = 1'b0;
    en_alu_den  = 1'b0;
    en_flags_in = 1'b0;
    case (step_q)
      S_T0: begin
        en_pc_den = 1'b1;
        en_mar_in = 1'b1;
      end
      S_T1: begin
        en_ram_den = 1'b1;
        en_ir_in   = 1'b1;
        en_pc_cnt  = 1'b1;
      end
      S_T2: begin
        if (i_opcode == OP_LDA || i_opcode == OP_ADD) begin
          en_ir_den = 1'b1;
          en_mar_in = 1'b1;
        end else if (jump_c) begin
          en_ir_den = 1'b1;
          en_pc_din = 1'b1;
        end
      end
      S_T3: begin
        if (i_opcode == OP_LDA) begin
          en_ram_den = 1'b1;
          en_a_in    = 1'b1;
        end else if (i_opcode == OP_ADD) begin
          en_ram_den = 1'b1;
          en_b_in    = 1'b1;
        end
      end
      S_T4: begin
        if (i_opcode == OP_ADD) begin
          en_alu_den  = 1'b1;
          en_a_in     = 1'b1;
          en_flags_in = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Reset and halt force every strobe inactive regardless of decode
  assign strobe_en_c = i_rstn & ~halt_q;

  assign o_pc_cntn   = ~(en_pc_cnt   & strobe_en_c);
  assign o_pc_den    = ~(en_pc_den   & strobe_en_c);
  assign o_pc_din    = ~(en_pc_din   & strobe_en_c);
  assign o_mar_inn   = ~(en_mar_in   & strobe_en_c);
  assign o_ram_den   = ~(en_ram_den  & strobe_en_c);
  assign o_ir_inn    = ~(en_ir_in    & strobe_en_c);
  assign o_ir_den    = ~(en_ir_den   & strobe_en_c);
  assign o_a_inn     = ~(en_a_in     & strobe_en_c);
  assign o_a_den     = 1'b1;
  assign o_b_inn     = ~(en_b_in     & strobe_en_c);
  assign o_alu_den   = ~(en_alu_den  & strobe_en_c);
  assign o_flags_inn = ~(en_flags_in & strobe_en_c);

  assign o_step = step_q;
  assign o_halt = halt_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed scenarios then random opcodes/flags/resets,
// all compared against a per-instruction behavioural model.
module tb_control_sequencer;

  logic       i_clk = 1'b0;
  logic       i_rstn;
  logic [3:0] i_opcode;
  logic       i_zero, i_carry, i_pc_overflow;
  logic o_pc_cntn, o_pc_den, o_pc_din, o_mar_inn, o_ram_den, o_ir_inn;
  logic o_ir_den, o_a_inn, o_a_den, o_b_inn, o_alu_den, o_flags_inn;
  logic [2:0] o_step;
  logic       o_halt;

  int n_checks = 0;
  int n_fail   = 0;
  int m_step   = 0;
  bit m_halt   = 1'b0;
  int halted_cycles = 0;

  // Strobe vector bit positions
  localparam int B_PC_CNT = 11, B_PC_DEN = 10, B_PC_DIN = 9, B_MAR_IN = 8;
  localparam int B_RAM_DEN = 7, B_IR_IN = 6, B_IR_DEN = 5, B_A_IN = 4;
  localparam int B_A_DEN = 3, B_B_IN = 2, B_ALU_DEN = 1, B_FLAGS_IN = 0;

  control_sequencer #(.NUM_STEPS(5), .OPC_W(4)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_opcode(i_opcode), .i_zero(i_zero),
    .i_carry(i_carry), .i_pc_overflow(i_pc_overflow),
    .o_pc_cntn(o_pc_cntn), .o_pc_den(o_pc_den), .o_pc_din(o_pc_din),
    .o_mar_inn(o_mar_inn), .o_ram_den(o_ram_den), .o_ir_inn(o_ir_inn),
    .o_ir_den(o_ir_den), .o_a_inn(o_a_inn), .o_a_den(o_a_den), .o_b_inn(o_b_inn),
    .o_alu_den(o_alu_den), .o_flags_inn(o_flags_inn), .o_step(o_step), .o_halt(o_halt)
  );

  always #5 i_clk = ~i_clk;

  // Set of units active in a given step of a given instruction
  function automatic logic [11:0] active_set(int st, logic [3:0] op, logic z, logic c);
    logic [11:0] r;
    logic is_jump;
    r = '0;
    is_jump = (op == 4'h3) || (op == 4'h4 && z) || (op == 4'h5 && c);
    if (st == 0) begin r[B_PC_DEN] = 1'b1; r[B_MAR_IN] = 1'b1; end
    if (st == 1) begin r[B_RAM_DEN] = 1'b1; r[B_IR_IN] = 1'b1; r[B_PC_CNT] = 1'b1; end
    if (st == 2 && (op == 4'h1 || op == 4'h2)) begin r[B_IR_DEN] = 1'b1; r[B_MAR_IN] = 1'b1; end
    if (st == 2 && is_jump) begin r[B_IR_DEN] = 1'b1; r[B_PC_DIN] = 1'b1; end
    if (st == 3 && op == 4'h1) begin r[B_RAM_DEN] = 1'b1; r[B_A_IN] = 1'b1; end
    if (st == 3 && op == 4'h2) begin r[B_RAM_DEN] = 1'b1; r[B_B_IN] = 1'b1; end
    if (st == 4 && op == 4'h2) begin
      r[B_ALU_DEN] = 1'b1; r[B_A_IN] = 1'b1; r[B_FLAGS_IN] = 1'b1;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    logic [11:0] obs, exp;
    int den_low;
    obs = {o_pc_cntn, o_pc_den, o_pc_din, o_mar_inn, o_ram_den, o_ir_inn,
           o_ir_den, o_a_inn, o_a_den, o_b_inn, o_alu_den, o_flags_inn};
    exp = (i_rstn && !m_halt) ? ~active_set(m_step, i_opcode, i_zero, i_carry) : 12'hFFF;
    den_low = 0;
    if (!o_pc_den)  den_low++;
    if (!o_ram_den) den_low++;
    if (!o_ir_den)  den_low++;
    if (!o_a_den)   den_low++;
    if (!o_alu_den) den_low++;
    check({tag, ".strobes"}, 32'(obs), 32'(exp));
    check({tag, ".step"}, 32'(o_step), 32'(m_step));
    check({tag, ".halt"}, 32'(o_halt), 32'(m_halt));
    check({tag, ".den_conflict"}, 32'(den_low > 1), 32'd0);
  endtask

  // Drive inputs away from the edge; async reset clears the model immediately
  task automatic apply(input logic rstn, input logic [3:0] op, input logic z,
                       input logic c, input logic ovf, input string tag);
    i_rstn = rstn; i_opcode = op; i_zero = z; i_carry = c; i_pc_overflow = ovf;
    if (!rstn) begin m_step = 0; m_halt = 1'b0; end
    #1;
    check_all(tag);
  endtask

  task automatic clk_edge();
    int  n_step;
    bit  n_halt;
    n_step = m_step;
    n_halt = m_halt;
    if (!i_rstn) begin
      n_step = 0; n_halt = 1'b0;
    end else if (!m_halt) begin
      if ((m_step == 1 && i_pc_overflow) || (m_step == 2 && i_opcode == 4'hF)) n_halt = 1'b1;
      else n_step = (m_step + 1) % 5;
    end
    @(posedge i_clk);
    #1;
    m_step = n_step;
    m_halt = n_halt;
  endtask

  task automatic run_instr(input logic [3:0] op, input logic z, input logic c, input string tag);
    for (int s = 0; s < 5; s++) begin
      apply(1'b1, op, z, c, 1'b0, tag);
      clk_edge();
    end
  endtask

  task automatic reset_pulse(input string tag);
    apply(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, {tag, ".rst"});
    apply(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, {tag, ".rel"});
  endtask

  initial begin
    i_rstn = 1'b0; i_opcode = 4'h2; i_zero = 1'b0; i_carry = 1'b0; i_pc_overflow = 1'b0;
    @(posedge i_clk); #1;
    apply(1'b0, 4'h2, 1'b1, 1'b1, 1'b1, "reset");
    clk_edge();
    apply(1'b0, 4'h2, 1'b1, 1'b1, 1'b1, "reset_held");
    apply(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, "release");
    check("release.pc_den", 32'(o_pc_den), 32'd0);

    for (int s = 0; s < 5; s++) begin
      apply(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, "nop");
      check("nop.step_seq", 32'(o_step), 32'(s));
      clk_edge();
    end

    run_instr(4'h2, 1'b0, 1'b0, "add");
    run_instr(4'h4, 1'b0, 1'b1, "jz_nz");
    run_instr(4'h4, 1'b1, 1'b0, "jz_z");
    run_instr(4'h5, 1'b1, 1'b1, "jc_c");
    run_instr(4'h5, 1'b0, 1'b0, "jc_nc");
    run_instr(4'h3, 1'b0, 1'b0, "jmp");
    run_instr(4'h1, 1'b0, 1'b0, "lda");
    run_instr(4'h9, 1'b1, 1'b1, "nop9");

    // HLT: halts at the step 2 edge and holds
    for (int s = 0; s < 3; s++) begin
      apply(1'b1, 4'hF, 1'b0, 1'b0, 1'b0, "hlt");
      clk_edge();
    end
    for (int k = 0; k < 10; k++) begin
      apply(1'b1, 4'h2, 1'b1, 1'b1, 1'b1, "hlt_hold");
      check("hlt_hold.o_step", 32'(o_step), 32'd2);
      check("hlt_hold.o_halt", 32'(o_halt), 32'd1);
      clk_edge();
    end
    reset_pulse("hlt_exit");
    run_instr(4'h0, 1'b0, 1'b0, "after_hlt");

    // Program-counter overflow during fetch
    apply(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, "ovf_s0");
    clk_edge();
    apply(1'b1, 4'h0, 1'b0, 1'b0, 1'b1, "ovf_s1");
    check("ovf_s1.pc_cntn", 32'(o_pc_cntn), 32'd0);
    clk_edge();
    apply(1'b1, 4'h1, 1'b0, 1'b0, 1'b0, "ovf_halted");
    check("ovf.o_halt", 32'(o_halt), 32'd1);
    reset_pulse("ovf_exit");

    // Reset mid-LDA at step 3: strobes released without a clock edge
    for (int s = 0; s < 3; s++) begin
      apply(1'b1, 4'h1, 1'b0, 1'b0, 1'b0, "lda_abort");
      clk_edge();
    end
    apply(1'b1, 4'h1, 1'b0, 1'b0, 1'b0, "lda_s3");
    check("lda_s3.ram_den", 32'(o_ram_den), 32'd0);
    apply(1'b0, 4'h1, 1'b0, 1'b0, 1'b0, "lda_async_rst");
    check("lda_async_rst.ram_den", 32'(o_ram_den), 32'd1);
    check("lda_async_rst.a_inn", 32'(o_a_inn), 32'd1);
    apply(1'b1, 4'h1, 1'b0, 1'b0, 1'b0, "lda_rst_rel");
    clk_edge();

    // Random phase
    for (int k = 0; k < 600; k++) begin
      logic [3:0] op;
      logic rstn, ovf;
      op   = 4'($urandom_range(0, 15));
      ovf  = ($urandom_range(0, 29) == 0);
      rstn = !($urandom_range(0, 59) == 0) && (halted_cycles < 4);
      apply(rstn, op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ovf, "rand");
      if (!rstn) begin
        halted_cycles = 0;
        apply(1'b1, op, i_zero, i_carry, ovf, "rand_rel");
      end
      if (m_halt) halted_cycles++;
      clk_edge();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
